// File: rtl/b2_slide_data_player.sv
// b2_slide_data_player: host-loaded frame buffer replayed in
// address order as eight 7-bit slide-data lanes over valid/ready.
module b2_slide_data_player #(
   parameter int DEPTH = 902,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [55:0]   load_data,
   output logic          load_err,
   input  logic          start,
   input  logic          stop,
   output logic          busy,
   output logic          done,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic [6:0]    Slide_data_0,
   output logic [6:0]    Slide_data_1,
   output logic [6:0]    Slide_data_2,
   output logic [6:0]    Slide_data_3,
   output logic [6:0]    Slide_data_4,
   output logic [6:0]    Slide_data_5,
   output logic [6:0]    Slide_data_6,
   output logic [6:0]    Slide_data_7
);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      DONE
   } state_t;

   // rd_ptr is one bit wider so it can reach DEPTH even when DEPTH == 2^AW
   localparam logic [AW:0] END_PTR  = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);

   state_t      state_q;
   state_t      state_d;
   logic [AW:0] rd_ptr;
   logic [55:0] mem [DEPTH];
   logic [55:0] data_q;
   logic        wr_ok;
   logic        wr_bad;
   logic        acc;
   logic        fin;
   logic        adv;

   always_comb begin
      wr_ok  = load_en && (state_q == IDLE)
               && ({1'b0, load_addr} < END_PTR);
      wr_bad = load_en && !wr_ok;
      acc    = out_valid && out_ready;
      fin    = acc && out_last;
      adv    = (state_q == PLAY) && (rd_ptr < END_PTR)
               && (!out_valid || out_ready);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = PLAY;
         end
         PLAY: begin
            if (stop)     state_d = IDLE;
            else if (fin) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Frame buffer has no reset so its contents survive rst_n
   always_ff @(posedge clk) begin
      if (wr_ok) mem[load_addr] <= load_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         data_q    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         load_err <= wr_bad;
         if (state_q == IDLE) begin
            if (start) rd_ptr <= '0;
         end else if (stop || fin) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else if (adv) begin
            data_q    <= mem[rd_ptr[AW-1:0]];
            out_valid <= 1'b1;
            out_last  <= (rd_ptr == LAST_PTR);
            rd_ptr    <= rd_ptr + 1'b1;
         end else if (acc) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

   assign Slide_data_0 = data_q[6:0];
   assign Slide_data_1 = data_q[13:7];
   assign Slide_data_2 = data_q[20:14];
   assign Slide_data_3 = data_q[27:21];
   assign Slide_data_4 = data_q[34:28];
   assign Slide_data_5 = data_q[41:35];
   assign Slide_data_6 = data_q[48:42];
   assign Slide_data_7 = data_q[55:49];

endmodule

// File: tb/tb_b2_slide_data_player.sv
// tb_b2_slide_data_player: randomized playback runs checked
// against an array model of the frame buffer and run rules.
module tb_b2_slide_data_player;

   localparam int DEPTH = 902;
   localparam int AW    = 10;

   logic          clk;
   logic          rst_n;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [55:0]   load_data;
   logic          load_err;
   logic          start;
   logic          stop;
   logic          busy;
   logic          done;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic [6:0]    sd0, sd1, sd2, sd3, sd4, sd5, sd6, sd7;
   logic [55:0]   lanes;

   logic [55:0]   exp_mem [DEPTH];
   int            n_chk;
   int            n_err;
   int            got;
   int            cycles;
   int            cnt;
   int            guard;
   int            runs;
   int            beats;
   int            gap;
   bit            seen;

   b2_slide_data_player #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_err     (load_err),
      .start        (start),
      .stop         (stop),
      .busy         (busy),
      .done         (done),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .Slide_data_0 (sd0),
      .Slide_data_1 (sd1),
      .Slide_data_2 (sd2),
      .Slide_data_3 (sd3),
      .Slide_data_4 (sd4),
      .Slide_data_5 (sd5),
      .Slide_data_6 (sd6),
      .Slide_data_7 (sd7)
   );

   assign lanes = {sd7, sd6, sd5, sd4, sd3, sd2, sd1, sd0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at a negedge; returns at the following negedge
   task automatic load(input int addr, input logic [55:0] d);
      bit ok;
      ok = (addr < DEPTH) && !busy;
      load_en   = 1'b1;
      load_addr = addr[AW-1:0];
      load_data = d;
      @(negedge clk);
      load_en = 1'b0;
      check("load_err", load_err, !ok);
      if (ok) exp_mem[addr] = d;
   endtask

   task automatic rnd56(output logic [55:0] d);
      d[31:0]  = $urandom;
      d[55:32] = 24'($urandom);
   endtask

   task automatic play(input int pct, input int stop_at, input bit bad_load,
                       input int pre_addr, output int n_got, output int n_cyc);
      bit          stall;
      logic [55:0] hd;
      logic [55:0] pd;
      n_got = 0;
      n_cyc = 0;
      stall = 1'b0;
      hd    = '0;
      start     = 1'b1;
      out_ready = 1'b0;
      if (pre_addr >= 0) begin
         rnd56(pd);
         load_en   = 1'b1;
         load_addr = pre_addr[AW-1:0];
         load_data = pd;
         exp_mem[pre_addr] = pd;
      end
      @(negedge clk);
      start   = 1'b0;
      load_en = 1'b0;
      check("busy_start", busy, 1);
      check("valid_lat1", out_valid, 0);
      if (pre_addr >= 0) check("preload_err", load_err, 0);
      if (bad_load) begin
         load_en   = 1'b1;
         load_addr = AW'(5);
         load_data = '1;
      end
      @(negedge clk);
      load_en = 1'b0;
      check("valid_lat2", out_valid, 1);
      check("play_load_err", load_err, bad_load);
      while (n_got < DEPTH) begin
         n_cyc++;
         if (n_cyc > 20000) begin
            check("timeout", n_cyc, 0);
            break;
         end
         if (stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", lanes, hd);
         end
         check("done_early", done, 0);
         if (out_valid) begin
            check("beat_data", lanes, exp_mem[n_got]);
            check("beat_last", out_last, n_got == DEPTH - 1);
         end
         if (n_got == stop_at) begin
            stop = 1'b1;
            @(negedge clk);
            stop      = 1'b0;
            out_ready = 1'b0;
            check("stop_valid", out_valid, 0);
            check("stop_busy", busy, 0);
            check("stop_done", done, 0);
            return;
         end
         out_ready = ($urandom_range(99) < pct);
         stall = out_valid && !out_ready;
         hd    = lanes;
         if (out_valid && out_ready) n_got++;
         @(negedge clk);
      end
      if (n_got == DEPTH) begin
         check("end_valid", out_valid, 0);
         check("end_done", done, 1);
         check("end_busy", busy, 1);
         @(negedge clk);
         check("idle_done", done, 0);
         check("idle_busy", busy, 0);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      logic [55:0] d;
      n_chk     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      start     = 1'b0;
      stop      = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_outs", {out_valid, out_last, done, busy, load_err}, 0);
      check("rst_lanes", lanes, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < DEPTH; k++) begin
         for (int n = 0; n < 8; n++) d[7*n +: 7] = 7'((k + n) % 128);
         load(k, d);
      end
      load(DEPTH, '1);
      load(1023, '1);

      play(100, -1, 1'b0, -1, got, cycles);
      check("run1_beats", got, DEPTH);
      check("run1_cycles", cycles, DEPTH);

      play(50, -1, 1'b1, -1, got, cycles);
      check("run2_beats", got, DEPTH);

      for (int i = 0; i < 16; i++) begin
         rnd56(d);
         load($urandom_range(1023), d);
      end

      play(50, -1, 1'b0, 7, got, cycles);
      check("run3_beats", got, DEPTH);

      play(70, 100, 1'b0, -1, got, cycles);
      check("stop_beats", got, 100);
      play(100, -1, 1'b0, -1, got, cycles);
      check("restart_beats", got, DEPTH);

      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt   = 0;
      guard = 0;
      while (cnt < 300 && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (out_valid) cnt++;
      end
      check("pre_reset_beats", cnt, 300);
      #2 rst_n = 1'b0;
      #1;
      check("arst_outs", {out_valid, out_last, done, busy, load_err}, 0);
      check("arst_lanes", lanes, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      play(60, -1, 1'b0, -1, got, cycles);
      check("post_reset_beats", got, DEPTH);

      runs  = 0;
      beats = 0;
      gap   = 0;
      guard = 0;
      seen  = 1'b0;
      start     = 1'b1;
      out_ready = 1'b1;
      while (runs < 2 && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (done) begin
            check("held_beats", beats, DEPTH);
            runs++;
            beats = 0;
            seen  = 1'b1;
            if (runs == 2) start = 1'b0;
         end else if (!busy && seen) begin
            gap++;
         end
         if (out_valid) beats++;
      end
      check("held_runs", runs, 2);
      check("held_gap", gap, 1);
      @(negedge clk);
      @(negedge clk);
      check("held_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
